// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
package uart_pkg;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_FRAME = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// done is high during the last clock of the stop bit, so the next state
// change in the consumer lines up with the end of the frame.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       start,
  input  logic       send,
  input  logic [7:0] data,
  output logic       out_uart_txd,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(BITS_PER_FRAME - 1);

  logic [CW-1:0]             cnt;
  logic [3:0]                bit_idx;
  logic [BITS_PER_FRAME-1:0] frame;

  assign done = busy && (bit_idx == LAST_BIT) && (cnt == LAST_CNT);

  // Bit-period counter and bit index walk the latched frame onto the line.
  always_ff @(posedge clk) begin
    if (start) begin
      busy         <= 1'b0;
      cnt          <= '0;
      bit_idx      <= '0;
      frame        <= '1;
      out_uart_txd <= STOP_BIT;
    end else if (!busy) begin
      if (send) begin
        busy         <= 1'b1;
        cnt          <= '0;
        bit_idx      <= '0;
        frame        <= {STOP_BIT, data, START_BIT};
        out_uart_txd <= START_BIT;
      end
    end else if (cnt != LAST_CNT) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      if (bit_idx == LAST_BIT) begin
        busy         <= 1'b0;
        bit_idx      <= '0;
        out_uart_txd <= STOP_BIT;
      end else begin
        bit_idx      <= bit_idx + 4'd1;
        out_uart_txd <= frame[bit_idx + 4'd1];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line among NUM_REQ clients.
// Handshake: a client holds req high with a stable byte; the byte is taken
// when the client is granted and ack pulses for one cycle after its stop bit.
// The client drops or updates req/req_bytes at the ack edge. With lock held
// the grant survives the ack so a multi-byte message stays contiguous.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 start,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [8*NUM_REQ-1:0] req_bytes,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 out_uart_txd,
  output logic                 busy,
  output logic                 result_ready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic [7:0]    tx_byte;
  logic [7:0]    winner_byte;
  logic [7:0]    owner_byte;
  logic          tx_send;
  logic          tx_busy;
  logic          tx_done;

  // First set request at or above the pointer, wrapping around.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PW-1:0] p);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    return (int'(w) == NUM_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] w);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  assign winner       = rr_pick(req, rr_ptr);
  assign winner_byte  = req_bytes[{winner, 3'b000} +: 8];
  assign owner_byte   = req_bytes[{owner, 3'b000} +: 8];
  assign busy         = (state != IDLE);
  assign result_ready = (state == IDLE) && !start;

  // Arbitration FSM; grant, ack and the serializer kick are all registered.
  always_ff @(posedge clk) begin
    ack     <= '0;
    tx_send <= 1'b0;
    if (start) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      owner   <= '0;
      tx_byte <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req) && !tx_busy) begin
            owner   <= winner;
            grant   <= onehot(winner);
            tx_byte <= winner_byte;
            tx_send <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (tx_done) begin
            ack   <= grant;
            state <= ACK;
          end
        end
        ACK: begin
          if (lock[owner]) begin
            state <= HOLD;
          end else begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr(owner);
          end
        end
        HOLD: begin
          if (req[owner]) begin
            tx_byte <= owner_byte;
            tx_send <= 1'b1;
            state   <= SEND;
          end else if (!lock[owner]) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk         (clk),
    .start       (start),
    .send        (tx_send),
    .data        (tx_byte),
    .out_uart_txd(out_uart_txd),
    .busy        (tx_busy),
    .done        (tx_done)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter (NUM_REQ=4, CLKS_PER_BIT=4).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        start;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] req_bytes;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        out_uart_txd;
  logic        busy;
  logic        result_ready;

  int vectors     = 0;
  int miscompares = 0;
  int m_rr        = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk         (clk),
    .start       (start),
    .req         (req),
    .lock        (lock),
    .req_bytes   (req_bytes),
    .grant       (grant),
    .ack         (ack),
    .out_uart_txd(out_uart_txd),
    .busy        (busy),
    .result_ready(result_ready)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference priority rule: first request at or above the pointer, wrapping.
  function automatic int m_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Follows one byte from grant to ack, decoding the line at bit centres.
  task automatic serve_expect(input int c, input logic [7:0] b,
                              input bit keep, input logic [7:0] nb);
    int         t;
    logic [7:0] got;
    logic [3:0] oh;
    oh = 4'(32'd1 << c);
    t = 0;
    while (grant == 4'd0 && t < 20) begin tick(1); t++; end
    chk("grant", grant, oh);
    t = 0;
    while (out_uart_txd !== 1'b0 && t < 20) begin tick(1); t++; end
    chk("start_bit", out_uart_txd, 0);
    tick(5);
    for (int i = 0; i < 8; i++) begin
      got[i] = out_uart_txd;
      tick(4);
    end
    chk("stop_bit", out_uart_txd, 1);
    chk("data", got, b);
    tick(2);
    chk("ack_early", ack, 0);
    tick(1);
    chk("ack", ack, oh);
    chk("grant_at_ack", grant, oh);
    if (keep) req_bytes[c*8 +: 8] = nb;
    else      req[c] = 1'b0;
    tick(1);
    chk("ack_width", ack, 0);
  endtask

  // Predicts the service order of a request set, then checks each byte.
  task automatic run_round(input logic [3:0] m);
    logic [11:0] exp_q[$];
    logic [11:0] e;
    logic [3:0]  rem;
    int          w;
    rem = m;
    while (rem != 4'd0) begin
      w = m_pick(rem, m_rr);
      exp_q.push_back({4'(w), req_bytes[w*8 +: 8]});
      rem[w] = 1'b0;
      m_rr   = (w + 1) % 4;
    end
    req = req | m;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      serve_expect(int'(e[11:8]), e[7:0], 1'b0, 8'h00);
    end
  endtask

  initial begin
    logic [3:0] m;
    start = 1'b1; req = '0; lock = '0; req_bytes = '0;

    // Reset
    tick(1);
    chk("rst_ready_low", result_ready, 0);
    chk("rst_txd", out_uart_txd, 1);
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    start = 1'b0;
    tick(1);
    chk("rst_ready", result_ready, 1);
    chk("rst_busy", busy, 0);

    // Single byte from client 2
    req_bytes[23:16] = 8'h41;
    req[2] = 1'b1;
    tick(1);
    chk("single_grant_lat", grant, 4'b0100);
    chk("single_txd_idle", out_uart_txd, 1);
    tick(1);
    chk("single_start_lat", out_uart_txd, 0);
    serve_expect(2, 8'h41, 1'b0, 8'h00);
    m_rr = 3;
    chk("single_idle_busy", busy, 0);
    chk("single_idle_ready", result_ready, 1);

    // Contention from rr_ptr=0
    start = 1'b1; tick(1); start = 1'b0; m_rr = 0;
    req_bytes = 32'h33_00_22_11;
    run_round(4'b1011);

    // Lock: client 1 sends three bytes while client 0 waits
    req_bytes[15:8] = 8'h35;
    lock[1] = 1'b1;
    req[1]  = 1'b1;
    tick(1);
    req_bytes[7:0] = 8'h5A;
    req[0] = 1'b1;
    serve_expect(1, 8'h35, 1'b1, 8'h0D);
    serve_expect(1, 8'h0D, 1'b0, 8'h00);
    tick(5);
    chk("hold_grant", grant, 4'b0010);
    chk("hold_busy", busy, 1);
    req_bytes[15:8] = 8'h0A;
    req[1] = 1'b1;
    tick(1);
    lock[1] = 1'b0;
    serve_expect(1, 8'h0A, 1'b0, 8'h00);
    serve_expect(0, 8'h5A, 1'b0, 8'h00);
    m_rr = 1;

    // Reset mid-frame: client 3 is cut off, then both are re-served from 0
    req_bytes[7:0]   = 8'hC3;
    req_bytes[31:24] = 8'h3C;
    req = 4'b1001;
    tick(1);
    chk("abort_grant", grant, 4'b1000);
    tick(1);
    chk("abort_start_bit", out_uart_txd, 0);
    tick(17);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("abort_txd", out_uart_txd, 1);
    chk("abort_grant_clr", grant, 0);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    m_rr = 0;
    req = 4'b0000;
    run_round(4'b1001);

    // Fairness: continuous requester 0 yields to client 3
    req_bytes[7:0] = 8'hA0;
    req[0] = 1'b1;
    tick(1);
    req_bytes[31:24] = 8'hB3;
    req[3] = 1'b1;
    serve_expect(0, 8'hA0, 1'b1, 8'hA1);
    serve_expect(3, 8'hB3, 1'b0, 8'h00);
    serve_expect(0, 8'hA1, 1'b0, 8'h00);
    m_rr = 1;

    // Random request sets with random bytes
    for (int round = 0; round < 12; round++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        if (m[i]) req_bytes[i*8 +: 8] = 8'($urandom);
      run_round(m);
      tick($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
